// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot or auto-reload mode.
// The period is loaded over a valid/ready handshake and the countdown is controlled with start/stop.
module countdown_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic [WIDTH-1:0]        reload_q, reload_d;
  logic [PRESCALE_W-1:0]   prescaler_q, prescaler_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic                    periodic_q, periodic_d;
  logic                    expired_q, expired_d;
  logic                    busy_q, busy_d;
  logic                    load_ready_q, load_ready_d;
  logic                    load_fire;
  logic                    tick;

  // load_ready_q is registered as (state != RUN), so it also gates loads during RUN
  assign load_fire = load_valid && load_ready_q;
  assign tick      = (prescaler_q == prescale_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    prescaler_d = prescaler_q;
    prescale_d  = prescale_q;
    periodic_d  = periodic_q;
    expired_d   = 1'b0;

    if (load_fire) begin
      count_d    = load_value;
      reload_d   = load_value;
      prescale_d = prescale;
      periodic_d = periodic;
      state_d    = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (start && !stop) begin
            prescaler_d = '0;
            // A zero period fires immediately and never enters RUN
            if (reload_q == '0) begin
              expired_d = 1'b1;
              count_d   = '0;
              state_d   = DONE;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            prescaler_d = '0;
            state_d     = ARMED;
          end else if (tick) begin
            prescaler_d = '0;
            // Terminal test uses <= 1 so the count can never wrap below zero
            if (count_q <= WIDTH'(1)) begin
              expired_d = 1'b1;
              if (periodic_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            prescaler_d = prescaler_q + PRESCALE_W'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d       = (state_d == RUN);
    load_ready_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      reload_q     <= '0;
      prescaler_q  <= '0;
      prescale_q   <= '0;
      periodic_q   <= 1'b0;
      expired_q    <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      prescaler_q  <= prescaler_d;
      prescale_q   <= prescale_d;
      periodic_q   <= periodic_d;
      expired_q    <= expired_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign count      = count_q;
  assign busy       = busy_q;
  assign expired    = expired_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Status vectors are packed as {count, busy, expired, load_ready}.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic [3:0] prescale;
  logic       periodic;
  logic       start;
  logic       stop;
  logic [7:0] count;
  logic       busy;
  logic       expired;

  int total;
  int bad;

  countdown_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .prescale   (prescale),
    .periodic   (periodic),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val, input logic [3:0] pre, input logic per);
    load_valid = 1'b1;
    load_value = val;
    prescale   = pre;
    periodic   = per;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_held: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_release: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL idle_start_ignored: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_cnt [4];
    logic [3:0] exp_bel [4];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
    exp_bel = '{4'b0, 4'b0, 4'b0, 4'b0};
    do_load(8'd3, 4'd0, 1'b0);
    total++;
    if ({count, busy, expired, load_ready} !== {8'd3, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL oneshot_loaded: got %h want %h", {count, busy, expired, load_ready}, {8'd3, 1'b0, 1'b0, 1'b1});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      // busy, expired, load_ready for E1..E3 are 1,0,0; at E4 they are 0,1,1
      exp_bel[i] = (i == 3) ? 4'b0011 : 4'b0100;
      total++;
      if ({count, busy, expired, load_ready} !== {exp_cnt[i], exp_bel[i][2:0]}) begin
        bad++;
        $display("[TB] FAIL oneshot_E%0d: got %h want %h", i + 1, {count, busy, expired, load_ready}, {exp_cnt[i], exp_bel[i][2:0]});
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL oneshot_done_hold: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp_cnt [9];
    logic       exp_exp [9];
    exp_cnt = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2};
    exp_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_load(8'd2, 4'd1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      total++;
      if ({count, busy, expired, load_ready} !== {exp_cnt[i], 1'b1, exp_exp[i], 1'b0}) begin
        bad++;
        $display("[TB] FAIL periodic_k%0d: got %h want %h", i, {count, busy, expired, load_ready}, {exp_cnt[i], 1'b1, exp_exp[i], 1'b0});
      end
      // A load request during RUN must not disturb the sequence
      load_valid = (i >= 1 && i <= 3);
      load_value = 8'd9;
      prescale   = 4'd0;
      periodic   = 1'b0;
    end
    load_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd2, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL periodic_stop: got %h want %h", {count, busy, expired, load_ready}, {8'd2, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_stop_resume();
    do_load(8'd5, 4'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++;
    if ({count, busy} !== {8'd3, 1'b1}) begin
      bad++;
      $display("[TB] FAIL stop_pre: got %h want %h", {count, busy}, {8'd3, 1'b1});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    total++;
    if ({count, busy, expired, load_ready} !== {8'd3, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL stop_hold: got %h want %h", {count, busy, expired, load_ready}, {8'd3, 1'b0, 1'b0, 1'b1});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired} !== {8'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL resume_start: got %h want %h", {count, busy, expired}, {8'd3, 1'b1, 1'b0});
    end
    step();
    step();
    total++;
    if ({count, busy, expired} !== {8'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL resume_mid: got %h want %h", {count, busy, expired}, {8'd1, 1'b1, 1'b0});
    end
    step();
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL resume_expire: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b1, 1'b1});
    end
    // Stop coinciding with terminal count wins, start+stop together also stops
    do_load(8'd1, 4'd0, 1'b0);
    start = 1'b1;
    step();
    stop = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL stop_at_terminal: got %h want %h", {count, busy, expired, load_ready}, {8'd1, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_load_priority();
    do_load(8'd4, 4'd0, 1'b0);
    load_valid = 1'b1;
    load_value = 8'd6;
    start      = 1'b1;
    step();
    load_valid = 1'b0;
    start      = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd6, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL load_beats_start: got %h want %h", {count, busy, expired, load_ready}, {8'd6, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_zero_period();
    do_load(8'd0, 4'd0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL zero_expire: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b1, 1'b1});
    end
    step();
    total++;
    if ({count, busy, expired} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL zero_after: got %h want %h", {count, busy, expired}, {8'd0, 1'b0, 1'b0});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL zero_done_start: got %h want %h", {count, busy, expired}, {8'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(8'd10, 4'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    total++;
    if ({count, busy} !== {8'd7, 1'b1}) begin
      bad++;
      $display("[TB] FAIL midrun_pre: got %h want %h", {count, busy}, {8'd7, 1'b1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({count, busy, expired, load_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL midrun_async: got %h want %h", {count, busy, expired, load_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
    end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if ({count, busy, expired} !== {8'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL midrun_post%0d: got %h want %h", i, {count, busy, expired}, {8'd0, 1'b0, 1'b0});
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_value = 8'd0;
    prescale   = 4'd0;
    periodic   = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_stop_resume();
    test_load_priority();
    test_zero_period();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
